// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with don't-care mask and runtime overlap mode.
// Optional saturating match counter is built when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detect_param #(
  parameter int                 PAT_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [PAT_W-1:0]   DEFAULT_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             data,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  output logic             flag,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   mask_q, mask_d;
  logic               overlap_q, overlap_d;
  logic               flag_q, flag_d;

  logic               accept_s;
  logic               window_full_s;
  logic [PAT_W-1:0]   hist_nxt_s;
  logic               match_s;

  always_comb begin
    accept_s      = data_valid & ~cfg_load;
    hist_nxt_s    = {hist_q[PAT_W-2:0], data};
    // The incoming bit completes a window once PAT_W-1 bits are already held.
    window_full_s = (state_q == ST_ARMED) || (fill_q == FILL_LAST);
    match_s       = accept_s && window_full_s &&
                    (((hist_nxt_s ^ pat_q) & mask_q) == {PAT_W{1'b0}});
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    overlap_d = overlap_q;
    flag_d    = 1'b0;

    if (cfg_load) begin
      pat_d     = cfg_pattern;
      mask_d    = cfg_mask;
      overlap_d = cfg_overlap;
      hist_d    = {PAT_W{1'b0}};
      fill_d    = {FILL_W{1'b0}};
      state_d   = ST_FILL;
    end else if (accept_s) begin
      hist_d = hist_nxt_s;
      fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      flag_d = match_s;
      case (state_q)
        ST_FILL: begin
          if (fill_q == FILL_LAST) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_ARMED: begin
          state_d = ST_ARMED;
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
      // Non-overlap mode restarts from an empty window after each hit.
      if (match_s && !overlap_q) begin
        hist_d  = {PAT_W{1'b0}};
        fill_d  = {FILL_W{1'b0}};
        state_d = ST_FILL;
      end else begin
        hist_d = hist_d;
      end
    end else begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      hist_q    <= {PAT_W{1'b0}};
      fill_q    <= {FILL_W{1'b0}};
      pat_q     <= DEFAULT_PAT;
      mask_q    <= {PAT_W{1'b1}};
      overlap_q <= 1'b1;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      overlap_q <= overlap_d;
      flag_q    <= flag_d;
    end
  end

  assign flag = flag_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: queue-based reference model plus literal pulse maps.
module tb_seq_detect_param;

  localparam int               PW    = 4;
  localparam int               CW    = 2;
  localparam logic [PW-1:0]    DPAT  = 4'b1011;
  localparam int               CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          data_valid;
  logic          data;
  logic          cfg_load;
  logic [PW-1:0] cfg_pattern;
  logic [PW-1:0] cfg_mask;
  logic          cfg_overlap;
  logic          flag;
  logic [CW-1:0] match_cnt;

  seq_detect_param #(.PAT_W(PW), .CNT_W(CW), .DEFAULT_PAT(DPAT)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .flag(flag), .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            q[$];
  logic [PW-1:0] m_pat;
  logic [PW-1:0] m_mask;
  logic          m_ovl;
  logic          exp_flag;
  int            exp_cnt;

  int            tick_idx;
  logic [31:0]   hits;
  int            pulses;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ok;
    if (!rst) begin
      q.delete();
      m_pat = DPAT; m_mask = {PW{1'b1}}; m_ovl = 1'b1;
      exp_flag = 1'b0; exp_cnt = 0;
    end else if (cfg_load) begin
      q.delete();
      m_pat = cfg_pattern; m_mask = cfg_mask; m_ovl = cfg_overlap;
      exp_flag = 1'b0; exp_cnt = 0;
    end else if (data_valid) begin
      q.push_back(data);
      if (q.size() > PW) void'(q.pop_front());
      exp_flag = 1'b0;
      if (q.size() == PW) begin
        ok = 1'b1;
        for (int i = 0; i < PW; i++)
          if (m_mask[PW-1-i] && (q[i] != m_pat[PW-1-i])) ok = 1'b0;
        if (ok) begin
          exp_flag = 1'b1;
`ifdef SEQ_DET_MATCH_CNT_EN
          if (exp_cnt < CMAX) exp_cnt++;
`endif
          if (!m_ovl) q.delete();
        end
      end
    end else begin
      exp_flag = 1'b0;
    end
  endtask

  // one clock: drive at negedge, model at posedge, compare at next negedge
  task automatic tick(input logic r, input logic v, input logic d, input logic ld);
    tick_idx++;
    rst = r; data_valid = v; data = d; cfg_load = ld;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("flag", int'(flag), int'(exp_flag));
    check("match_cnt", int'(match_cnt), exp_cnt);
    if (flag === 1'b1) begin
      pulses++;
      if (tick_idx < 32) hits[tick_idx] = 1'b1;
    end
    cfg_load = 1'b0;
  endtask

  task automatic begin_test();
    tick_idx = 0; hits = 32'd0; pulses = 0;
  endtask

  task automatic load(input logic [PW-1:0] p, input logic [PW-1:0] m, input logic o);
    cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tick(1'b1, 1'b1, bits[i], 1'b0);
  endtask

  logic [31:0] exp_hits;

  initial begin
    rst = 1'b0; data_valid = 1'b0; data = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 4'b0000; cfg_mask = 4'b0000; cfg_overlap = 1'b0;
    exp_flag = 1'b0; exp_cnt = 0; m_pat = DPAT; m_mask = 4'b1111; m_ovl = 1'b1;
    @(negedge clk);

    // reset state, with cfg_load and data_valid asserted during reset
    begin_test();
    cfg_pattern = 4'b0000; cfg_mask = 4'b0000;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("reset_flag", int'(flag), 0);
    check("reset_cnt", int'(match_cnt), 0);

    // 1: default cfg, 1,0,1,1,0,1,1,1
    begin_test();
    stream(32'b10110111, 8);
    exp_hits = (32'd1 << 4) | (32'd1 << 7);
    check("t1_hits", hits, exp_hits);
    check("t1_pulses", pulses, 2);

    // 2: non-overlap then overlap
    begin_test();
    load(4'b1011, 4'b1111, 1'b0);
    stream(32'b1011011, 7);
    exp_hits = 32'd1 << 5;
    check("t2_novl_hits", hits, exp_hits);
    begin_test();
    load(4'b1011, 4'b1111, 1'b1);
    stream(32'b1011011, 7);
    exp_hits = (32'd1 << 5) | (32'd1 << 8);
    check("t2_ovl_hits", hits, exp_hits);

    // 3: all-zero pattern must not match reset history
    begin_test();
    load(4'b0000, 4'b1111, 1'b1);
    stream(32'b00000, 5);
    exp_hits = (32'd1 << 5) | (32'd1 << 6);
    check("t3_hits", hits, exp_hits);

    // 4: masked pattern, non-overlap
    begin_test();
    load(4'b1001, 4'b1001, 1'b0);
    stream(32'b11011001, 8);
    exp_hits = (32'd1 << 5) | (32'd1 << 9);
    check("t4_hits", hits, exp_hits);

    // 5: gaps are transparent; reset mid-stream drops history
    begin_test();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    exp_hits = 32'd1 << 8;
    check("t5_gap_hits", hits, exp_hits);
    begin_test();
    stream(32'b101, 3);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_rst_pulses", pulses, 0);

    // cfg_load discards a simultaneous data bit
    begin_test();
    load(4'b1111, 4'b1111, 1'b1);
    data_valid = 1'b1; data = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    stream(32'b111, 3);
    check("ld_discard_pulses", pulses, 0);
    stream(32'b1, 1);
    check("ld_discard_hit", pulses, 1);

    // 6: mask all zero gives back-to-back pulses and a saturating count
    begin_test();
    load(4'b0000, 4'b0000, 1'b1);
    stream(32'b10110010, 8);
    check("t6_pulses", pulses, 5);
    exp_hits = 32'h1F << 5;
    check("t6_hits", hits, exp_hits);
`ifdef SEQ_DET_MATCH_CNT_EN
    check("t6_cnt_sat", int'(match_cnt), 3);
`else
    check("t6_cnt_tied", int'(match_cnt), 0);
`endif
    load(4'b0000, 4'b0000, 1'b1);
    check("t6_cnt_clear", int'(match_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
